// File: rtl/font_glyph_renderer.sv
// Font glyph renderer: reads one glyph row at a time from a synchronous font ROM
// and streams its pixels MSB first over a valid/ready handshake. Row r+1 is
// prefetched into a next-row buffer while row r shifts, so rows run back to back.
module font_glyph_renderer #(
  parameter int GLYPH_ROWS = 16,
  parameter int ROW_BITS   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_glyph,
  output logic [7:0]          rom_ad,
  output logic                rom_ce,
  output logic                rom_oce,
  input  logic [ROW_BITS-1:0] rom_dout,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_data,
  output logic                pix_eol,
  output logic                pix_eog
);

  localparam logic [4:0] LAST_COL = 5'(ROW_BITS - 1);
  localparam logic [3:0] LAST_ROW = 4'(GLYPH_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t              state;
  logic [3:0]          glyph;
  logic [4:0]          col;
  logic [3:0]          row;
  logic [ROW_BITS-1:0] shreg;
  logic [ROW_BITS-1:0] nbuf;
  logic                nbuf_full;
  logic                pf_p1;

  // Request, ROM read sequencing, row prefetch and pixel shifting in one registered FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      pix_valid <= 1'b0;
      glyph     <= '0;
      col       <= '0;
      row       <= '0;
      shreg     <= '0;
      nbuf      <= '0;
      nbuf_full <= 1'b0;
      pf_p1     <= 1'b0;
      rom_ce    <= 1'b0;
      rom_ad    <= '0;
    end else begin
      // Read strobes are single-cycle pulses; address is parked at zero otherwise
      rom_ce <= 1'b0;
      rom_ad <= '0;
      // A prefetch read issued last cycle has its data on rom_dout now
      pf_p1  <= rom_ce && (state == SHIFT);
      if (pf_p1 && !nbuf_full) begin
        nbuf      <= rom_dout;
        nbuf_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            glyph     <= req_glyph;
            req_ready <= 1'b0;
            col       <= '0;
            row       <= '0;
            rom_ce    <= 1'b1;
            rom_ad    <= {req_glyph, 4'd0};
            state     <= FIRST;
          end
        end

        FIRST: state <= LOAD;

        LOAD: begin
          shreg     <= rom_dout;
          pix_valid <= 1'b1;
          state     <= SHIFT;
          if (GLYPH_ROWS > 1) begin
            rom_ce <= 1'b1;
            rom_ad <= {glyph, 4'd1};
          end
        end

        SHIFT: begin
          if (pix_ready) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (row == LAST_ROW) begin
                row       <= '0;
                nbuf_full <= 1'b0;
                pix_valid <= 1'b0;
                req_ready <= 1'b1;
                state     <= IDLE;
              end else begin
                row       <= row + 4'd1;
                shreg     <= nbuf;
                nbuf_full <= 1'b0;
                // Prefetch the row after the one being entered, unless it is the last
                if ((row + 4'd1) < LAST_ROW) begin
                  rom_ce <= 1'b1;
                  rom_ad <= {glyph, row + 4'd2};
                end
              end
            end else begin
              col   <= col + 5'd1;
              shreg <= {shreg[ROW_BITS-2:0], 1'b0};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign rom_oce  = 1'b1;
  assign pix_data = shreg[ROW_BITS-1];
  assign pix_eol  = pix_valid && (col == LAST_COL);
  assign pix_eog  = pix_eol && (row == LAST_ROW);

endmodule

// File: tb/tb_font_glyph_renderer.sv
// Bench for font_glyph_renderer: a synchronous ROM model plus a reference pixel
// stream built from the glyph/row word pattern, driven through directed steps.
module tb_font_glyph_renderer;
  localparam int GLYPH_ROWS = 16;
  localparam int ROW_BITS   = 32;
  localparam int NPIX       = GLYPH_ROWS * ROW_BITS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_glyph = 4'd0;
  logic [7:0]  rom_ad;
  logic        rom_ce;
  logic        rom_oce;
  logic [31:0] rom_dout = 32'd0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        pix_data;
  logic        pix_eol;
  logic        pix_eog;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] addr_q[$];
  int ad_bad = 0;

  always #5 clk = ~clk;

  font_glyph_renderer #(.GLYPH_ROWS(GLYPH_ROWS), .ROW_BITS(ROW_BITS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_glyph(req_glyph),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_eol(pix_eol), .pix_eog(pix_eog)
  );

  function automatic logic [31:0] word(input logic [3:0] g, input logic [3:0] r);
    return {g, r, 20'h5A5A5, r};
  endfunction

  // Font ROM with one-cycle read latency; also logs every read address
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_dout <= word(rom_ad[7:4], rom_ad[3:0]);
      addr_q.push_back(rom_ad);
    end else if (rom_ad != 8'd0) begin
      ad_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_data"},  pix_data, 0);
    chk({tag, "_pix_eol"},   pix_eol, 0);
    chk({tag, "_pix_eog"},   pix_eog, 0);
    chk({tag, "_rom_ce"},    rom_ce, 0);
    chk({tag, "_rom_ad"},    rom_ad, 0);
    chk({tag, "_rom_oce"},   rom_oce, 1);
  endtask

  task automatic render(input logic [3:0] g, input int low_pct, input bit long_stall,
                        input int reset_at, input bit check_cycles);
    logic       exp_q[$];
    logic [31:0] w;
    logic [2:0] prev_out;
    int  p, cyc, stall_left, wait_n, n;
    bit  stalled_once, prev_stall;
    for (int r = 0; r < GLYPH_ROWS; r++) begin
      w = word(g, 4'(r));
      for (int c = 0; c < ROW_BITS; c++) exp_q.push_back(w[ROW_BITS-1-c]);
    end

    wait_n = 0;
    while (!req_ready && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    chk("req_ready_before_accept", req_ready, 1);
    if (!req_ready) return;
    addr_q.delete();
    ad_bad = 0;

    req_valid = 1'b1;
    req_glyph = g;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_glyph = 4'($urandom);
    chk("req_ready_after_accept", req_ready, 0);
    chk("first_rom_ce", rom_ce, 1);
    chk("first_rom_ad", rom_ad, {24'd0, g, 4'd0});
    @(posedge clk); #1;
    chk("load_pix_valid", pix_valid, 0);
    @(posedge clk); #1;
    chk("first_pix_valid", pix_valid, 1);

    p = 0; cyc = 0; stall_left = 0; stalled_once = 0; prev_stall = 0; prev_out = '0;
    while (p < NPIX && cyc < 6000) begin
      chk("pix_valid", pix_valid, 1);
      chk("pix_data", pix_data, exp_q[p]);
      chk("pix_eol", pix_eol, (p % ROW_BITS) == ROW_BITS - 1);
      chk("pix_eog", pix_eog, p == NPIX - 1);
      if (prev_stall) chk("stall_hold", {pix_data, pix_eol, pix_eog}, prev_out);
      if (reset_at == p) begin
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        pix_ready = 1'b0;
        return;
      end
      if (long_stall && !stalled_once && p == 5 * ROW_BITS + ROW_BITS - 1) begin
        stall_left = 100;
        stalled_once = 1;
      end
      if (stall_left > 0) begin
        pix_ready = 1'b0;
        stall_left--;
      end else begin
        pix_ready = ($urandom_range(0, 99) >= low_pct);
      end
      prev_stall = !pix_ready;
      prev_out = {pix_data, pix_eol, pix_eog};
      @(posedge clk); #1;
      cyc++;
      if (!prev_stall) p++;
    end
    pix_ready = 1'b0;
    chk("glyph_done_in_budget", p, NPIX);
    chk("req_ready_after_eog", req_ready, 1);
    chk("pix_valid_after_eog", pix_valid, 0);
    if (check_cycles) chk("cycles_for_glyph", cyc, NPIX);
    chk("rom_ce_count", addr_q.size(), GLYPH_ROWS);
    n = (addr_q.size() < GLYPH_ROWS) ? addr_q.size() : GLYPH_ROWS;
    for (int i = 0; i < n; i++) chk("rom_ad_seq", addr_q[i], {24'd0, g, 4'(i)});
    chk("rom_ad_zero_when_idle", ad_bad, 0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_held");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_reset", req_ready, 1);

    render(4'd3, 0, 0, -1, 1);
    render(4'd3, 30, 0, -1, 0);
    render(4'd7, 0, 1, -1, 0);
    render(4'($urandom), 30, 0, 200, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_after_mid");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_midreset", req_ready, 1);
    render(4'd1, 0, 0, -1, 1);
    render(4'd0, 20, 0, -1, 0);
    render(4'd15, 20, 0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
